// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers for the EX stage.
// A latched operation completes after a fixed, parameterised number of busy cycles.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // op_q[0] selects unsigned, op_q[1] selects divide
    always_comb begin
        a_ext = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;

        a_neg = ~op_q[0] & a_q[WIDTH-1];
        b_neg = ~op_q[0] & b_q[WIDTH-1];
        a_mag = a_neg ? WIDTH'(0) - a_q : a_q;
        b_mag = b_neg ? WIDTH'(0) - b_q : b_q;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;

        // Most-negative / -1 falls out of the magnitude path as {hi,lo} = {0, most-negative}
        if (!op_q[1]) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_lo = (a_neg ^ b_neg) ? WIDTH'(0) - q_mag : q_mag;
            res_hi = a_neg ? WIDTH'(0) - r_mag : r_mag;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        if (state_q == IDLE) begin
            // start always drops a concurrent move; flush only suppresses the launch
            if (start) begin
                if (!flush) begin
                    op_d    = md_op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end else begin
                if (hi_write) hi_d = wdata;
                if (lo_write) lo_d = wdata;
            end
        end else begin
            if (flush) begin
                cnt_d   = '0;
                state_d = IDLE;
                busy_d  = 1'b0;
            end else if (cnt_q == CW'(1)) begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                cnt_d   = '0;
                state_d = IDLE;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and busy length are queued at launch
// and retired by a monitor whenever busy falls.
module tb_md_unit;

    localparam int unsigned W  = 32;
    localparam int          MC = 5;
    localparam int          DC = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   md_op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         hi_write = 1'b0, lo_write = 1'b0, flush = 1'b0;
    logic         busy;
    logic [W-1:0] hi, lo;

    logic         s_reset = 1'b0, s_start = 1'b0;
    logic [1:0]   s_md_op = 2'b00;
    logic [7:0]   s_a = '0, s_b = '0, s_wdata = '0;
    logic         s_hi_write = 1'b0, s_lo_write = 1'b0, s_flush = 1'b0;
    logic         s_busy;
    logic [7:0]   s_hi, s_lo;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata), .flush(flush),
        .busy(busy), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(8), .MULT_CYCLES(1)) dut8 (
        .clk(clk), .reset(s_reset), .start(s_start), .md_op(s_md_op), .a(s_a), .b(s_b),
        .hi_write(s_hi_write), .lo_write(s_lo_write), .wdata(s_wdata), .flush(s_flush),
        .busy(s_busy), .hi(s_hi), .lo(s_lo)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cycles;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           busy_cnt = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {hi,lo} from plain signed/unsigned 64-bit arithmetic
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'(int'(x));
        sy = longint'(int'(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (op)
            2'b00: return 64'(sx * sy);
            2'b01: return ux * uy;
            2'b10: begin
                if (y == '0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (y == '0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom % 7)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: a falling busy is the "result valid" event
    always @(negedge clk) begin
        if (busy) begin
            busy_cnt <= busy_cnt + 1;
        end else if (busy_cnt > 0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=busy_fall expected=none at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
            end
            busy_cnt <= 0;
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int flush_at, input int glitch_at, input bit mv_with_start);
        int          n;
        exp_t        e;
        logic [63:0] r;
        n = op[1] ? DC : MC;
        if (flush_at >= 1 && flush_at <= n) begin
            e.hi = m_hi; e.lo = m_lo; e.cycles = flush_at;
        end else begin
            r = ref_md(op, x, y);
            m_hi = r[63:32]; m_lo = r[31:0];
            e.hi = m_hi; e.lo = m_lo; e.cycles = n;
        end
        sb_q.push_back(e);
        md_op = op; a = x; b = y; start = 1'b1;
        if (mv_with_start) begin
            hi_write = 1'b1; lo_write = 1'b1; wdata = $urandom;
        end
        @(posedge clk) #1;
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        for (int i = 1; i <= n; i++) begin
            a = $urandom; b = $urandom; md_op = 2'($urandom);
            if (i == glitch_at) begin
                start = 1'b1; md_op = 2'b00; hi_write = 1'b1; lo_write = 1'($urandom); wdata = 32'h1234;
            end
            if (i == flush_at) flush = 1'b1;
            @(posedge clk) #1;
            start = 1'b0; hi_write = 1'b0; lo_write = 1'b0; flush = 1'b0;
            if (i == flush_at) break;
        end
        @(posedge clk) #1;
    endtask

    task automatic mv(input bit hw, input bit lw, input logic [W-1:0] d);
        hi_write = hw; lo_write = lw; wdata = d;
        @(posedge clk) #1;
        hi_write = 1'b0; lo_write = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        check("move_hi", 64'(hi), 64'(m_hi));
        check("move_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, fa, ga;
        logic [15:0] p8;
        #2 reset = 1'b1; s_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        reset = 1'b0; s_reset = 1'b0;
        @(posedge clk) #1;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0);
        check("tp_mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("tp_mult_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 1'b0);
        check("tp_multu_hi", 64'(hi), 64'h1);
        check("tp_multu_lo", 64'(lo), 64'hFFFF_FFFE);
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, 1'b0);
        check("tp_mult2_hi", 64'(hi), 64'hFFFF_FFFF);
        check("tp_mult2_lo", 64'(lo), 64'hFFFF_FFFE);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        check("tp_div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("tp_div_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(2'b11, 32'd5, 32'd0, 0, 0, 1'b0);
        check("tp_divz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("tp_divz_hi", 64'(hi), 64'd5);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4, 1'b0);
        check("tp_ovf_lo", 64'(lo), 64'h8000_0000);
        check("tp_ovf_hi", 64'(hi), 64'h0);
        run_op(2'b00, 32'd3, 32'd9, 0, MC, 1'b0);

        mv(1'b1, 1'b0, 32'hAAAA);
        mv(1'b0, 1'b1, 32'h5555);
        run_op(2'b00, 32'd4, 32'd4, 2, 0, 1'b0);
        check("tp_flush_hi", 64'(hi), 64'hAAAA);
        check("tp_flush_lo", 64'(lo), 64'h5555);
        flush = 1'b1;
        @(posedge clk) #1;
        flush = 1'b0;
        check("idle_flush_hi", 64'(hi), 64'hAAAA);
        run_op(2'b01, 32'd6, 32'd7, 0, 0, 1'b1);
        mv(1'b1, 1'b1, 32'hDEAD_BEEF);

        // Launch suppressed when flush coincides with start in IDLE
        md_op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk) #1;
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", 64'(busy), 64'(0));

        for (int k = 0; k < 28; k++) begin
            logic [1:0] op;
            op = 2'($urandom);
            n  = op[1] ? DC : MC;
            fa = ($urandom % 4 == 0) ? int'($urandom_range(n, 1)) : 0;
            ga = ($urandom % 3 == 0) ? int'($urandom_range(n, 1)) : 0;
            run_op(op, pick(), pick(), fa, ga, ($urandom % 5) == 0);
            if ($urandom % 4 == 0) mv(1'($urandom), 1'($urandom), $urandom);
        end

        // Asynchronous reset in the middle of a divu
        begin
            exp_t e;
            e.hi = '0; e.lo = '0; e.cycles = 3;
            sb_q.push_back(e);
            md_op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
            @(posedge clk) #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk) #1;
            reset = 1'b1;
            #1;
            check("rst_mid_busy", 64'(busy), 64'(0));
            check("rst_mid_hi", 64'(hi), 64'(0));
            check("rst_mid_lo", 64'(lo), 64'(0));
            m_hi = '0; m_lo = '0;
            @(posedge clk) #1;
            reset = 1'b0;
            @(posedge clk) #1;
        end

        s_md_op = 2'b01; s_a = 8'hFF; s_b = 8'hFF; s_start = 1'b1;
        @(posedge clk) #1;
        s_start = 1'b0;
        @(negedge clk);
        check("w8_busy_on", 64'(s_busy), 64'(1));
        @(negedge clk);
        check("w8_busy_off", 64'(s_busy), 64'(0));
        check("w8_hi", 64'(s_hi), 64'hFE);
        check("w8_lo", 64'(s_lo), 64'h01);
        for (int k = 0; k < 6; k++) begin
            s_md_op = 2'(k % 2); s_a = 8'($urandom); s_b = 8'($urandom);
            if (k % 2 == 0) p8 = 16'(int'($signed(s_a)) * int'($signed(s_b)));
            else            p8 = {8'b0, s_a} * {8'b0, s_b};
            s_start = 1'b1;
            @(posedge clk) #1;
            s_start = 1'b0;
            @(posedge clk) #1;
            check("w8_rand_busy", 64'(s_busy), 64'(0));
            check("w8_rand_hilo", 64'({s_hi, s_lo}), 64'(p8));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
